// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the modulo up/down counter and its adder slices.
//   SLICE_W     : width of one ripple adder slice (4 bits)
//   nslices()   : number of slices needed for a given counter width
//   count_dir_e : counting direction, decoded from the 'up' input
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int unsigned SLICE_W = 4;

  function automatic int unsigned nslices(input int unsigned width);
    return width / SLICE_W;
  endfunction

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

endpackage

// File: rtl/adder_slice4.sv
// -----------------------------------------------------------------------------
// adder_slice4
// One 4-bit slice of the counter's ripple-carry increment/decrement chain.
// Ports:
//   a    in  4  counter nibble
//   b    in  4  step nibble (true or inverted)
//   cin  in  1  carry from the lower slice
//   sum  out 4  result nibble
//   cout out 1  carry to the upper slice
// -----------------------------------------------------------------------------
module adder_slice4
  import counter_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + (SLICE_W + 1)'(cin);
  end

  assign sum  = total[SLICE_W-1:0];
  assign cout = total[SLICE_W];

endmodule

// File: rtl/modulo_updown_counter.sv
// -----------------------------------------------------------------------------
// modulo_updown_counter
// Parametrised up/down modulo counter with programmable terminal value,
// enable, synchronous load, terminal-count and wrap flags. The +/-STEP path
// is a ripple chain of adder_slice4 instances.
//
// Parameters:
//   WIDTH : counter width, nonzero multiple of 4
//   STEP  : amount added/subtracted per enabled cycle, 1 <= STEP < 2**WIDTH
//
// Ports:
//   clk      in  1      clock, rising edge
//   reset    in  1      asynchronous, active-high; clears count and wrap
//   en       in  1      count enable
//   up       in  1      1 = count up, 0 = count down
//   load     in  1      synchronous load, priority over en
//   load_val in  WIDTH  value captured on load (not range-checked)
//   max_val  in  WIDTH  terminal value; range is 0..max_val
//   count    out WIDTH  registered count
//   tc       out 1      up ? (count >= max_val) : (count == 0)
//   wrap     out 1      registered pulse, aligned with the wrapped count
//
// Configuration macro:
//   COUNTER_SATURATE_EN : clamp at 0 / max_val instead of wrapping;
//                         wrap is then always 0.
// -----------------------------------------------------------------------------
module modulo_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam int unsigned      NS     = nslices(WIDTH);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  if (WIDTH == 0 || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("modulo_updown_counter: WIDTH must be a nonzero multiple of 4");
  end

  if (STEP == 0 || (WIDTH < 32 && 64'(STEP) >= (64'd1 << WIDTH))) begin : g_bad_step
    $error("modulo_updown_counter: STEP must satisfy 1 <= STEP < 2**WIDTH");
  end

  count_dir_e       dir;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
  logic [NS:0]      carry;
  logic             carry_out;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  assign dir = up ? DIR_UP : DIR_DOWN;

  // Subtraction reuses the adder chain as count + ~STEP + 1; the final carry
  // is then the inverted borrow, i.e. high when count >= STEP.
  assign operand  = (dir == DIR_UP) ? STEP_V : ~STEP_V;
  assign carry[0] = (dir == DIR_DOWN);

  for (genvar i = 0; i < NS; i++) begin : g_slice
    adder_slice4 u_slice (
      .a    (count[i*SLICE_W +: SLICE_W]),
      .b    (operand[i*SLICE_W +: SLICE_W]),
      .cin  (carry[i]),
      .sum  (result[i*SLICE_W +: SLICE_W]),
      .cout (carry[i+1])
    );
  end

  assign carry_out = carry[NS];

  assign tc = (dir == DIR_UP) ? (count >= max_val) : (count == '0);

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        // tc also catches loaded values already above max_val; carry_out
        // catches sums that overflow WIDTH and would otherwise look small.
        if (tc || carry_out || (result > max_val)) begin
`ifdef COUNTER_SATURATE_EN
          count_next = max_val;
`else
          count_next = '0;
          wrap_next  = 1'b1;
`endif
        end else begin
          count_next = result;
        end
      end else begin
        if (carry_out) begin
          count_next = result;
        end else begin
`ifdef COUNTER_SATURATE_EN
          count_next = '0;
`else
          count_next = max_val;
          wrap_next  = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

endmodule
